// File: rtl/rdclk_read_fifo_if.sv
// Handshake bundle for rdclk_read_fifo: write request side, valid/ready
// read side with first-word fall-through, and status outputs.
interface rdclk_read_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic [AW:0]      count;
  logic             overflow;

  // Producer/consumer environment driving the FIFO.
  modport master (
    output wr_en, wr_data, rd_ready,
    input  full, rd_valid, rd_data, count, overflow
  );

  // The FIFO itself.
  modport slave (
    input  wr_en, wr_data, rd_ready,
    output full, rd_valid, rd_data, count, overflow
  );
endinterface

// File: rtl/rdclk_read_fifo.sv
// Single-clock read-side FIFO clocked by rdclk. Holds up to DEPTH words and
// presents the head word combinationally (first-word fall-through). Status
// flags derive from the registered count only. Writes while full are dropped
// and latch a sticky overflow flag that only reset clears.
module rdclk_read_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                 rdclk,
  input  logic                 rst_n,
  rdclk_read_fifo_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full_w, valid_w;
  logic             do_wr, do_rd;

  // Flags from registered count; accept/pop qualifiers; next-state values.
  always_comb begin
    full_w     = (count_q == (AW+1)'(DEPTH));
    valid_w    = (count_q != '0);
    // A full FIFO never writes, even if a pop frees a slot this same edge.
    do_wr      = bus.wr_en && !full_w;
    do_rd      = valid_w && bus.rd_ready;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (bus.wr_en && full_w);
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_wr && !do_rd)      count_d = count_q + (AW+1)'(1);
    else if (do_rd && !do_wr) count_d = count_q - (AW+1)'(1);
  end

  // Pointer, occupancy and sticky-flag registers.
  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples pre-edge values regardless of statement order.
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage write port.
  // NOTE: the array has no reset; emptiness is tracked by count, so stale
  // contents are never presented as valid, and the array maps to plain RAM.
  always_ff @(posedge rdclk) begin
    if (do_wr) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.full     = full_w;
  assign bus.rd_valid = valid_w;
  assign bus.rd_data  = mem_q[rd_ptr_q];
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
endmodule

// File: doc/rdclk_read_fifo.md
Name: rdclk_read_fifo

Overview:
- Read-side buffer clocked by a port named `rdclk`, as an input.
- It is the consumer of the `rdclk` that read-clock source blocks drive out, so v2x must classify this input as a clock, just as it does the output form.
- Holds up to DEPTH words written in the same domain and presents them on a valid/ready read port with first-word fall-through.
- Also used as the sequential companion in clock-detection tests: the port name `rdclk` plus its use as an edge reference must yield clock classification.

Parameters:
- WIDTH, 8, data word width in bits (≥1).
- DEPTH, 4, number of storage entries; power of two, ≥2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- rdclk  input  1  sole clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset. Assertion is asynchronous; release is sampled on `rdclk`.
- wr_en  input  1  write request.
- wr_data  input  WIDTH  write data.
- full  output  1  high when count == DEPTH.
- rd_valid  output  1  head word present; equals !empty.
- rd_ready  input  1  consumer accepts head word.
- rd_data  output  WIDTH  head word. Undefined-but-stable when rd_valid is low.
- count  output  AW+1  number of stored words, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - wr_ptr = rd_ptr = 0, count = 0.
  - full = 0, rd_valid = 0, overflow = 0.
  - Storage contents are not reset.
- Write:
  - Accepted at a rising edge when wr_en && !full.
  - wr_data is stored at wr_ptr, then wr_ptr increments modulo DEPTH.
- Read (pop):
  - Occurs at a rising edge when rd_valid && rd_ready; rd_ptr increments modulo DEPTH.
  - rd_data is combinational from mem[rd_ptr] (first-word fall-through).
- Latency:
  - A word written at edge N gives rd_valid = 1 and rd_data = that word immediately after edge N.
  - A pop at edge N presents the next word, or deasserts rd_valid, after edge N.
- count:
  - +1 on write only, −1 on pop only, unchanged on both or neither.
  - full = (count == DEPTH); rd_valid = (count != 0). Both are derived from registered count, so there are no combinational paths from inputs.
- Full boundary:
  - wr_en while full is dropped; data and pointers are unchanged and overflow is set.
  - This holds even if a pop occurs in the same cycle: no write-through when full.
- Empty boundary:
  - rd_ready while empty is ignored; there is no underflow flag and pointers are unchanged.
- Simultaneous write and pop when 0 < count < DEPTH: both occur and count is unchanged.
- Simultaneous write and pop when count == 0: the pop is ignored (rd_valid is low) and the write occurs.
- Pointer wrap: pointers wrap from DEPTH−1 to 0 with no gap or duplicate; ordering is strictly FIFO.
- overflow: cleared only by reset; not cleared by pops.
- Reset mid-operation: all stored words are discarded immediately. rd_valid drops asynchronously with rst_n, and the first post-release write behaves as on an empty FIFO.
- Contains no other clocks, no enables on rdclk, and no gated or derived clocks. rdclk is used only as an edge reference.

Test Plan:
- Reset then idle, rd_ready = 1 for 5 cycles -> rd_valid = 0, count = 0, full = 0, overflow = 0 throughout.
- Write 0xA1, 0xB2, 0xC3 on consecutive edges with rd_ready = 0 -> count 1, 2, 3. rd_data = 0xA1 from the edge after the first write. Then rd_ready = 1 for 3 cycles -> rd_data 0xA1, 0xB2, 0xC3, after which rd_valid = 0.
- Fill with 0x10..0x13 (DEPTH = 4) -> full = 1, count = 4. Write 0x99 with rd_ready = 1 on the same edge -> 0x10 popped, 0x99 dropped, count = 3, overflow = 1. Drain -> 0x11, 0x12, 0x13 only.
- Continuous write and pop of 0..9 with rd_ready = 1 -> count stays at 1 after the first write. rd_data follows 0..9 in order across two pointer wraps.
- Write 0x55 and 0x66, then pulse rst_n low mid-cycle -> rd_valid and count go to 0 without waiting for an edge. After release, writing 0x77 -> rd_data = 0x77, count = 1, overflow = 0.
- Elaboration check: v2x output for the module classifies `rdclk` as a clock input and `rst_n`, `wr_en`, `rd_ready` as data inputs.
